control_unit: RTL and testbench

//   Moore FSM that sequences the 8-bit accumulator datapath through fetch/decode/execute.

---
 rtl/control_unit_pkg.sv | 90 +++++++++
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
//   Shared definitions for the accumulator-CPU controller: opcode values,
//   state codes (also visible on the State debug port), A-source select
//   encodings, the bundled strobe struct and small decode helpers.
//   Imported by control_unit and usable by the datapath top level.
// -----------------------------------------------------------------------------
package control_unit_pkg;

    // Opcodes, taken from IR[7:5]
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Accumulator source select
    localparam logic [1:0] ASEL_ALU  = 2'b00;
    localparam logic [1:0] ASEL_IN   = 2'b01;
    localparam logic [1:0] ASEL_RAM  = 2'b10;
    localparam logic [1:0] ASEL_ZERO = 2'b11;

    // Controller states. Codes 14 and 15 are unused and recover to StStart.
    typedef enum logic [3:0] {
        StStart  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StLoad   = 4'd3,
        StStore  = 4'd4,
        StAdd    = 4'd5,
        StSub    = 4'd6,
        StIn     = 4'd7,
        StInRel  = 4'd8,
        StJz     = 4'd9,
        StJpos   = 4'd10,
        StHalt   = 4'd11,
        StFetchW = 4'd12,
        StOperW  = 4'd13
    } state_e;

    // All datapath strobes in one bundle so the output decode can default them at once.
    typedef struct packed {
        logic       ir_load;
        logic       jmp_mux;
        logic       pc_load;
        logic       mem_inst;
        logic       mem_wr;
        logic [1:0] a_sel;
        logic       a_load;
        logic       sub;
        logic       halt;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_IDLE = '{
        ir_load:  1'b0,
        jmp_mux:  1'b0,
        pc_load:  1'b0,
        mem_inst: 1'b0,
        mem_wr:   1'b0,
        a_sel:    ASEL_ALU,
        a_load:   1'b0,
        sub:      1'b0,
        halt:     1'b0
    };

    // Execute state reached from DECODE for a given opcode.
    function automatic state_e exec_state(input logic [2:0] op);
        state_e st;
        unique case (op)
            OP_LOAD:  st = StLoad;
            OP_STORE: st = StStore;
            OP_ADD:   st = StAdd;
            OP_SUB:   st = StSub;
            OP_IN:    st = StIn;
            OP_JZ:    st = StJz;
            OP_JPOS:  st = StJpos;
            default:  st = StHalt;
        endcase
        return st;
    endfunction

    // Opcodes whose execute cycle consumes RAM read data at the operand address.
    function automatic logic reads_operand(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Moore FSM sequencing the 8-bit accumulator datapath through
//   fetch / decode / execute. Every strobe is decoded from the state register;
//   the only input-dependent outputs are the conditional jump strobes in
//   JZ/JPOS and Aload in IN (gated by the operator Enter strobe).
//
// Parameters
//   RD_WAIT  0: RAM read data valid in the address cycle.
//            1: data valid one cycle later; a wait state precedes FETCH and
//               the RAM-consuming LOAD/ADD/SUB execute states.
//
// Ports
//   Clock    in   system clock, posedge
//   Reset    in   synchronous active-high; next state START
//   IR       in   [2:0] opcode (IR register bits 7:5)
//   Aeq0     in   accumulator == 0
//   Apos     in   accumulator bit 7 == 0
//   Enter    in   operator strobe for IN (level, already synchronised)
//   IRload   out  load IR from RAM data
//   JMPmux   out  PC source: 0 PC+1, 1 IR[4:0]
//   PCload   out  load PC
//   Meminst  out  RAM address: 0 PC, 1 IR[4:0]
//   MemWr    out  write A to RAM[IR[4:0]]
//   Asel     out  [1:0] A source: 00 ALU, 01 input, 10 RAM, 11 zero
//   Aload    out  load A
//   Sub      out  ALU op: 0 add, 1 subtract
//   Halt     out  high in HALT
//   State    out  [3:0] current state code
// -----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned RD_WAIT = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] State
);

    // Where every instruction returns to: the fetch wait state when RAM is slow.
    localparam state_e FetchEntry = (RD_WAIT != 0) ? StFetchW : StFetch;
    localparam logic   UseOperW   = (RD_WAIT != 0);

    state_e    state_q, state_d;
    ctrl_out_t ctrl;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StStart:  state_d = FetchEntry;
            StFetchW: state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                // IR is stable from here until the next FETCH, so OPER_W can
                // re-decode it rather than remembering the opcode.
                if (UseOperW && reads_operand(IR)) begin
                    state_d = StOperW;
                end else begin
                    state_d = exec_state(IR);
                end
            end
            StOperW:  state_d = exec_state(IR);
            StLoad,
            StStore,
            StAdd,
            StSub,
            StJz,
            StJpos:   state_d = FetchEntry;
            StIn:     state_d = Enter ? StInRel : StIn;
            // Wait for release so a held Enter loads A only once.
            StInRel:  state_d = Enter ? StInRel : FetchEntry;
            StHalt:   state_d = StHalt;
            default:  state_d = StStart;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            StFetch: begin
                ctrl.ir_load = 1'b1;
                ctrl.pc_load = 1'b1;
            end
            // Operand address is presented early so slow or fast RAM has it ready.
            StDecode,
            StOperW: ctrl.mem_inst = 1'b1;
            StLoad: begin
                ctrl.mem_inst = 1'b1;
                ctrl.a_sel    = ASEL_RAM;
                ctrl.a_load   = 1'b1;
            end
            StStore: begin
                ctrl.mem_inst = 1'b1;
                ctrl.mem_wr   = 1'b1;
            end
            StAdd: begin
                ctrl.mem_inst = 1'b1;
                ctrl.a_sel    = ASEL_ALU;
                ctrl.a_load   = 1'b1;
            end
            StSub: begin
                ctrl.mem_inst = 1'b1;
                ctrl.a_sel    = ASEL_ALU;
                ctrl.a_load   = 1'b1;
                ctrl.sub      = 1'b1;
            end
            StIn: begin
                ctrl.a_sel  = ASEL_IN;
                ctrl.a_load = Enter;
            end
            StJz: begin
                ctrl.jmp_mux = Aeq0;
                ctrl.pc_load = Aeq0;
            end
            StJpos: begin
                ctrl.jmp_mux = Apos;
                ctrl.pc_load = Apos;
            end
            StHalt:  ctrl.halt = 1'b1;
            default: ctrl = CTRL_IDLE;
        endcase
    end

    assign IRload  = ctrl.ir_load;
    assign JMPmux  = ctrl.jmp_mux;
    assign PCload  = ctrl.pc_load;
    assign Meminst = ctrl.mem_inst;
    assign MemWr   = ctrl.mem_wr;
    assign Asel    = ctrl.a_sel;
    assign Aload   = ctrl.a_load;
    assign Sub     = ctrl.sub;
    assign Halt    = ctrl.halt;
    assign State   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for control_unit. Two instances share all inputs: one with
//   RD_WAIT=0 and one with RD_WAIT=1. Strobes are packed as
//   {IRload,JMPmux,PCload,Meminst,MemWr,Asel[1:0],Aload,Sub,Halt}.
// -----------------------------------------------------------------------------
module tb_control_unit;

    // State codes
    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_ADD    = 4'd5;
    localparam logic [3:0] S_SUB    = 4'd6;
    localparam logic [3:0] S_IN     = 4'd7;
    localparam logic [3:0] S_INREL  = 4'd8;
    localparam logic [3:0] S_JZ     = 4'd9;
    localparam logic [3:0] S_JPOS   = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd11;
    localparam logic [3:0] S_FETCHW = 4'd12;
    localparam logic [3:0] S_OPERW  = 4'd13;

    // Expected strobe vectors
    localparam logic [9:0] O_ZERO  = 10'b0000000000;
    localparam logic [9:0] O_FETCH = 10'b1010000000;
    localparam logic [9:0] O_DEC   = 10'b0001000000;
    localparam logic [9:0] O_LOAD  = 10'b0001010100;
    localparam logic [9:0] O_STORE = 10'b0001100000;
    localparam logic [9:0] O_ADD   = 10'b0001000100;
    localparam logic [9:0] O_SUB   = 10'b0001000110;
    localparam logic [9:0] O_IN0   = 10'b0000001000;
    localparam logic [9:0] O_IN1   = 10'b0000001100;
    localparam logic [9:0] O_JMP   = 10'b0110000000;
    localparam logic [9:0] O_HALT  = 10'b0000000001;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] IR    = 3'b000;
    logic       Aeq0  = 1'b0;
    logic       Apos  = 1'b0;
    logic       Enter = 1'b0;

    logic       ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_load, sub, halt;
    logic [1:0] a_sel;
    logic [3:0] state;
    logic       r_ir_load, r_jmp_mux, r_pc_load, r_mem_inst, r_mem_wr, r_a_load, r_sub, r_halt;
    logic [1:0] r_a_sel;
    logic [3:0] r_state;
    logic [9:0] outs, r_outs;

    int n_total = 0;
    int n_pass  = 0;

    always #5 Clock = ~Clock;

    assign outs   = {ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_sel, a_load, sub, halt};
    assign r_outs = {r_ir_load, r_jmp_mux, r_pc_load, r_mem_inst, r_mem_wr, r_a_sel,
                     r_a_load, r_sub, r_halt};

    control_unit #(.RD_WAIT(0)) u_dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(ir_load), .JMPmux(jmp_mux), .PCload(pc_load), .Meminst(mem_inst),
        .MemWr(mem_wr), .Asel(a_sel), .Aload(a_load), .Sub(sub), .Halt(halt), .State(state)
    );

    control_unit #(.RD_WAIT(1)) u_dut_rw (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(r_ir_load), .JMPmux(r_jmp_mux), .PCload(r_pc_load), .Meminst(r_mem_inst),
        .MemWr(r_mem_wr), .Asel(r_a_sel), .Aload(r_a_load), .Sub(r_sub), .Halt(r_halt),
        .State(r_state)
    );

    // Stimulus only: leaves both DUTs in START with Reset just released.
    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1;
        Enter = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        n_total++;
        if (state !== S_START || outs !== O_ZERO)
            $display("FAIL reset: state=%0d outs=%b, want state=%0d outs=%b",
                     state, outs, S_START, O_ZERO);
        else n_pass++;
        n_total++;
        if (r_state !== S_START || r_outs !== O_ZERO)
            $display("FAIL reset_rw: state=%0d outs=%b, want state=%0d outs=%b",
                     r_state, r_outs, S_START, O_ZERO);
        else n_pass++;
        Reset = 1'b0;
        @(negedge Clock);
        n_total++;
        if (state !== S_FETCH || outs !== O_FETCH)
            $display("FAIL reset_release: state=%0d outs=%b, want state=%0d outs=%b",
                     state, outs, S_FETCH, O_FETCH);
        else n_pass++;
    endtask

    task automatic test_fetch_load();
        logic [3:0] es [4];
        logic [9:0] eo [4];
        es = '{S_FETCH, S_DECODE, S_LOAD, S_FETCH};
        eo = '{O_FETCH, O_DEC, O_LOAD, O_FETCH};
        do_reset();
        IR = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            n_total++;
            if (state !== es[i] || outs !== eo[i])
                $display("FAIL fetch_load[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, es[i], eo[i]);
            else n_pass++;
        end
    endtask

    task automatic test_add_sub_store();
        logic [2:0] ops [3];
        logic [3:0] xs  [3];
        logic [9:0] xo  [3];
        logic [3:0] es;
        logic [9:0] eo;
        ops = '{3'b010, 3'b011, 3'b001};
        xs  = '{S_ADD, S_SUB, S_STORE};
        xo  = '{O_ADD, O_SUB, O_STORE};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            IR = ops[k];
            for (int i = 0; i < 3; i++) begin
                es = (i == 0) ? S_FETCH : (i == 1) ? S_DECODE : xs[k];
                eo = (i == 0) ? O_FETCH : (i == 1) ? O_DEC : xo[k];
                @(negedge Clock);
                n_total++;
                if (state !== es || outs !== eo)
                    $display("FAIL alu_op%0d[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                             k, i, state, outs, es, eo);
                else n_pass++;
            end
        end
    endtask

    task automatic test_branches();
        logic [2:0] ops [4];
        logic       zf  [4];
        logic       pf  [4];
        logic [3:0] xs  [4];
        logic [9:0] xo  [4];
        logic [3:0] es;
        logic [9:0] eo;
        ops = '{3'b101, 3'b101, 3'b110, 3'b110};
        zf  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pf  = '{1'b0, 1'b1, 1'b1, 1'b0};
        xs  = '{S_JZ, S_JZ, S_JPOS, S_JPOS};
        xo  = '{O_JMP, O_ZERO, O_JMP, O_ZERO};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            IR   = ops[k];
            Aeq0 = zf[k];
            Apos = pf[k];
            for (int i = 0; i < 3; i++) begin
                es = (i == 0) ? S_FETCH : (i == 1) ? S_DECODE : xs[k];
                eo = (i == 0) ? O_FETCH : (i == 1) ? O_DEC : xo[k];
                @(negedge Clock);
                n_total++;
                if (state !== es || outs !== eo)
                    $display("FAIL branch%0d[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                             k, i, state, outs, es, eo);
                else n_pass++;
            end
        end
        @(negedge Clock);
        n_total++;
        if (state !== S_FETCH)
            $display("FAIL branch_return: state=%0d, want state=%0d", state, S_FETCH);
        else n_pass++;
        Aeq0 = 1'b0;
        Apos = 1'b0;
    endtask

    task automatic test_in_handshake();
        int loads = 0;
        do_reset();
        IR    = 3'b100;
        Enter = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            loads += int'(a_load);
            n_total++;
            if (state !== S_IN || outs !== O_IN0)
                $display("FAIL in_wait[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, S_IN, O_IN0);
            else n_pass++;
        end
        Enter = 1'b1;
        #1;
        loads += int'(a_load);
        n_total++;
        if (state !== S_IN || outs !== O_IN1)
            $display("FAIL in_enter: state=%0d outs=%b, want state=%0d outs=%b",
                     state, outs, S_IN, O_IN1);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            loads += int'(a_load);
            n_total++;
            if (state !== S_INREL || outs !== O_ZERO)
                $display("FAIL in_rel[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, S_INREL, O_ZERO);
            else n_pass++;
        end
        Enter = 1'b0;
        @(negedge Clock);
        n_total++;
        if (state !== S_FETCH)
            $display("FAIL in_done: state=%0d, want state=%0d", state, S_FETCH);
        else n_pass++;
        n_total++;
        if (loads !== 1)
            $display("FAIL in_load_count: loads=%0d, want loads=1", loads);
        else n_pass++;
    endtask

    task automatic test_halt();
        int bad = 0;
        do_reset();
        IR = 3'b111;
        @(negedge Clock);
        @(negedge Clock);
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            IR    = 3'(i);
            Enter = i[0];
            n_total++;
            if (state !== S_HALT || outs !== O_HALT) begin
                bad++;
                $display("FAIL halt[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, S_HALT, O_HALT);
            end else n_pass++;
        end
        Enter = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        IR    = 3'b100;
        Enter = 1'b0;
        repeat (4) @(negedge Clock);
        n_total++;
        if (state !== S_IN)
            $display("FAIL mid_in_setup: state=%0d, want state=%0d", state, S_IN);
        else n_pass++;
        Reset = 1'b1;
        Enter = 1'b1;
        @(negedge Clock);
        n_total++;
        if (state !== S_START || outs !== O_ZERO)
            $display("FAIL reset_in_wait: state=%0d outs=%b, want state=%0d outs=%b",
                     state, outs, S_START, O_ZERO);
        else n_pass++;
        Reset = 1'b0;
        Enter = 1'b0;
        IR    = 3'b111;
        repeat (3) @(negedge Clock);
        n_total++;
        if (state !== S_HALT)
            $display("FAIL mid_halt_setup: state=%0d, want state=%0d", state, S_HALT);
        else n_pass++;
        Reset = 1'b1;
        @(negedge Clock);
        n_total++;
        if (state !== S_START || outs !== O_ZERO)
            $display("FAIL reset_halt: state=%0d outs=%b, want state=%0d outs=%b",
                     state, outs, S_START, O_ZERO);
        else n_pass++;
        Reset = 1'b0;
        @(negedge Clock);
        n_total++;
        if (state !== S_FETCH)
            $display("FAIL reset_halt_release: state=%0d, want state=%0d", state, S_FETCH);
        else n_pass++;
    endtask

    task automatic test_rd_wait();
        logic [2:0] ops [3];
        logic [3:0] xs  [3];
        logic [9:0] xo  [3];
        logic [3:0] es [6];
        logic [9:0] eo [6];
        int         len;
        ops = '{3'b000, 3'b010, 3'b001};
        xs  = '{S_LOAD, S_ADD, S_STORE};
        xo  = '{O_LOAD, O_ADD, O_STORE};
        for (int k = 0; k < 3; k++) begin
            es[0] = S_FETCHW; eo[0] = O_ZERO;
            es[1] = S_FETCH;  eo[1] = O_FETCH;
            es[2] = S_DECODE; eo[2] = O_DEC;
            if (k < 2) begin
                es[3] = S_OPERW;  eo[3] = O_DEC;
                es[4] = xs[k];    eo[4] = xo[k];
                es[5] = S_FETCHW; eo[5] = O_ZERO;
                len = 6;
            end else begin
                es[3] = xs[k];    eo[3] = xo[k];
                es[4] = S_FETCHW; eo[4] = O_ZERO;
                len = 5;
            end
            do_reset();
            IR = ops[k];
            for (int i = 0; i < len; i++) begin
                @(negedge Clock);
                n_total++;
                if (r_state !== es[i] || r_outs !== eo[i])
                    $display("FAIL rd_wait_op%0d[%0d]: state=%0d outs=%b, want state=%0d outs=%b",
                             k, i, r_state, r_outs, es[i], eo[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_load();
        test_add_sub_store();
        test_branches();
        test_in_handshake();
        test_halt();
        test_reset_mid_op();
        test_rd_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
